// File: rtl/tcp_rx_app_buf_responder_pkg.sv
// rtl/tcp_rx_app_buf_responder_pkg.sv - NoC flit layouts, ring pointer types and constants for the TCP RX app-pointer responder
package tcp_rx_app_buf_responder_pkg;

    localparam int NOC_DATA_WIDTH    = 256;
    localparam int MAX_FLOWID_W      = 4;
    localparam int MAX_NUM_BUFS      = 8;
    localparam int MAX_PAYLOAD_IDX_W = 3;
    localparam int PTR_W             = MAX_PAYLOAD_IDX_W + 1;
    localparam int TCP_BUF_W         = 48;
    localparam int XY_WIDTH          = 8;
    localparam int FBITS_WIDTH       = 4;
    localparam int MSG_LEN_WIDTH     = 22;
    localparam int MSG_TYPE_WIDTH    = 8;

    localparam logic [FBITS_WIDTH-1:0]    TCP_RX_APP_PTR_IF_FBITS = 4'd5;
    localparam logic [MSG_TYPE_WIDTH-1:0] TCP_MSG_REQ_TYPE        = 8'h40;
    localparam logic [MSG_TYPE_WIDTH-1:0] TCP_MSG_RESP_TYPE       = 8'h41;
    localparam logic [MSG_TYPE_WIDTH-1:0] TCP_ADJUST_IDX_TYPE     = 8'h42;

    typedef logic [PTR_W-1:0] ring_ptr_t;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_UPDATE = 2'd3
    } resp_state_e;

    typedef struct packed {
        logic [31:0] ptr;
        logic [15:0] len;
    } tcp_buf;

    typedef struct packed {
        ring_ptr_t prod;
        ring_ptr_t hand;
        ring_ptr_t cons;
    } tcp_buf_ring_ptrs;

    typedef struct packed {
        logic [XY_WIDTH-1:0]       dst_x;
        logic [XY_WIDTH-1:0]       dst_y;
        logic [FBITS_WIDTH-1:0]    dst_fbits;
        logic [MSG_LEN_WIDTH-1:0]  msg_len;
        logic [MSG_TYPE_WIDTH-1:0] msg_type;
        logic [XY_WIDTH-1:0]       src_x;
        logic [XY_WIDTH-1:0]       src_y;
        logic [FBITS_WIDTH-1:0]    src_fbits;
    } noc_hdr_core;

    typedef struct packed {
        ring_ptr_t idx;
        tcp_buf    buf_info;
    } tcp_buf_with_idx;

    localparam int CORE_W       = 70;
    localparam int RESP_PAD_W   = NOC_DATA_WIDTH - CORE_W - MAX_FLOWID_W - TCP_BUF_W - PTR_W;
    localparam int ADJUST_PAD_W = NOC_DATA_WIDTH - CORE_W - MAX_FLOWID_W - TCP_BUF_W - PTR_W - 8 - 16;

    // Request and response share this layout; a request leaves buf_info/idx zero.
    typedef struct packed {
        noc_hdr_core             core;
        logic [MAX_FLOWID_W-1:0] flowid;
        tcp_buf                  buf_info;
        ring_ptr_t               idx;
        logic [RESP_PAD_W-1:0]   padding;
    } tcp_noc_hdr_flit;

    typedef struct packed {
        noc_hdr_core             core;
        logic [MAX_FLOWID_W-1:0] flowid;
        tcp_buf_with_idx         prev_buf;
        logic [7:0]              bufs_consumed;
        logic [15:0]             leftover_bytes_consumed;
        logic [ADJUST_PAD_W-1:0] padding;
    } tcp_adjust_idx_flit;

    // Wrap bit makes prod - cons exact for occupancies 0..MAX_NUM_BUFS.
    function automatic logic ring_full(input ring_ptr_t prod, input ring_ptr_t cons);
        ring_ptr_t used;
        used = prod - cons;
        return used == ring_ptr_t'(MAX_NUM_BUFS);
    endfunction

endpackage

// File: rtl/tcp_rx_app_buf_responder_table.sv
// rtl/tcp_rx_app_buf_responder_table.sv - tcp_buf_ring_table: per-flow prod/hand/cons pointers and buffer storage
module tcp_buf_ring_table
    import tcp_rx_app_buf_responder_pkg::*;
#(
    parameter int NUM_FLOWS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fill_val_i,
    input  logic [MAX_FLOWID_W-1:0] fill_flowid_i,
    input  logic [TCP_BUF_W-1:0]    fill_buf_i,
    output logic                    fill_rdy_o,
    input  logic [MAX_FLOWID_W-1:0] q_flowid_i,
    output logic                    q_flow_ok_o,
    output logic                    q_avail_o,
    output logic [TCP_BUF_W-1:0]    q_buf_o,
    output logic [PTR_W-1:0]        q_hand_o,
    output logic [PTR_W-1:0]        q_cons_o,
    input  logic                    hand_adv_i,
    input  logic                    cons_adv_i
);

    localparam int          FLOW_IDX_W  = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
    localparam int          FLOW_SLOTS  = 1 << FLOW_IDX_W;
    localparam int          MEM_AW      = FLOW_IDX_W + MAX_PAYLOAD_IDX_W;
    localparam logic [31:0] NUM_FLOWS_U = 32'(NUM_FLOWS);

    tcp_buf_ring_ptrs        ptrs_q [FLOW_SLOTS];
    tcp_buf_ring_ptrs        ptrs_d [FLOW_SLOTS];
    logic [TCP_BUF_W-1:0]    mem_q  [1 << MEM_AW];

    logic [FLOW_IDX_W-1:0]   fill_idx;
    logic [FLOW_IDX_W-1:0]   q_idx;
    logic                    fill_flow_ok;
    logic                    fill_we;
    ring_ptr_t               fill_prod;
    ring_ptr_t               fill_cons;
    ring_ptr_t               q_prod;

    assign fill_idx     = fill_flowid_i[FLOW_IDX_W-1:0];
    assign q_idx        = q_flowid_i[FLOW_IDX_W-1:0];
    assign fill_flow_ok = 32'(fill_flowid_i) < NUM_FLOWS_U;
    assign q_flow_ok_o  = 32'(q_flowid_i) < NUM_FLOWS_U;

    assign fill_prod  = ptrs_q[fill_idx].prod;
    assign fill_cons  = ptrs_q[fill_idx].cons;
    assign fill_rdy_o = fill_flow_ok && !ring_full(fill_prod, fill_cons);
    assign fill_we    = fill_val_i && fill_rdy_o;

    // All reads use registered pointers, so a same-cycle fill or retire is never seen early.
    assign q_prod    = ptrs_q[q_idx].prod;
    assign q_hand_o  = ptrs_q[q_idx].hand;
    assign q_cons_o  = ptrs_q[q_idx].cons;
    assign q_avail_o = q_flow_ok_o && (q_hand_o != q_prod);
    assign q_buf_o   = mem_q[{q_idx, q_hand_o[MAX_PAYLOAD_IDX_W-1:0]}];

    always_comb begin
        ptrs_d = ptrs_q;
        if (fill_we) begin
            ptrs_d[fill_idx].prod = fill_prod + 1'b1;
        end
        if (hand_adv_i && q_flow_ok_o) begin
            ptrs_d[q_idx].hand = q_hand_o + 1'b1;
        end
        if (cons_adv_i && q_flow_ok_o) begin
            ptrs_d[q_idx].cons = q_cons_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FLOW_SLOTS; i++) begin
                ptrs_q[i] <= '0;
            end
        end else begin
            ptrs_q <= ptrs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[{fill_idx, fill_prod[MAX_PAYLOAD_IDX_W-1:0]}] <= fill_buf_i;
        end
    end

endmodule

// File: rtl/tcp_rx_app_buf_responder.sv
// rtl/tcp_rx_app_buf_responder.sv - TCP RX app-pointer NoC responder: request/adjust FSM around a per-flow buffer ring
module tcp_rx_app_buf_responder
    import tcp_rx_app_buf_responder_pkg::*;
#(
    parameter int                  NUM_FLOWS = 8,
    parameter logic [XY_WIDTH-1:0] SRC_X     = '0,
    parameter logic [XY_WIDTH-1:0] SRC_Y     = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      noc_resp_in_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc_resp_in_data,
    output logic                      noc_resp_in_rdy,
    output logic                      resp_noc_out_val,
    output logic [NOC_DATA_WIDTH-1:0] resp_noc_out_data,
    input  logic                      resp_noc_out_rdy,
    input  logic                      fill_val,
    input  logic [MAX_FLOWID_W-1:0]   fill_flowid,
    input  logic [TCP_BUF_W-1:0]      fill_buf,
    output logic                      fill_rdy,
    output logic                      adjust_err
);

    localparam logic [31:0] NUM_FLOWS_U = 32'(NUM_FLOWS);

    resp_state_e                 state_q, state_d;
    logic [NOC_DATA_WIDTH-1:0]   flit_q, flit_d;
    logic [NOC_DATA_WIDTH-1:0]   resp_q, resp_d;

    tcp_noc_hdr_flit             in_view;
    tcp_noc_hdr_flit             req_view;
    tcp_adjust_idx_flit          adj_view;
    tcp_noc_hdr_flit             resp_flit;

    logic                        in_hs;
    logic                        in_flow_ok;
    logic                        adj_ok;
    logic                        hand_adv;
    logic                        cons_adv;
    logic                        q_flow_ok;
    logic                        q_avail;
    logic [TCP_BUF_W-1:0]        q_buf;
    logic [PTR_W-1:0]            q_hand;
    logic [PTR_W-1:0]            q_cons;
    logic                        unused_flit_bits;

    assign in_view    = noc_resp_in_data;
    assign req_view   = flit_q;
    assign adj_view   = flit_q;
    assign in_hs      = noc_resp_in_val && (state_q == ST_READY);
    assign in_flow_ok = 32'(in_view.flowid) < NUM_FLOWS_U;

    // Out-of-range flows reach UPDATE only so that the rejection pulse is raised.
    assign adj_ok = q_flow_ok
                 && (adj_view.prev_buf.idx == q_cons)
                 && (adj_view.bufs_consumed == 8'd1)
                 && (adj_view.leftover_bytes_consumed == 16'd0)
                 && (q_cons != q_hand);

    assign unused_flit_bits = ^{in_view, req_view, adj_view};

    tcp_buf_ring_table #(
        .NUM_FLOWS (NUM_FLOWS)
    ) u_ring (
        .clk           (clk),
        .rst_n         (rst_n),
        .fill_val_i    (fill_val),
        .fill_flowid_i (fill_flowid),
        .fill_buf_i    (fill_buf),
        .fill_rdy_o    (fill_rdy),
        .q_flowid_i    (req_view.flowid),
        .q_flow_ok_o   (q_flow_ok),
        .q_avail_o     (q_avail),
        .q_buf_o       (q_buf),
        .q_hand_o      (q_hand),
        .q_cons_o      (q_cons),
        .hand_adv_i    (hand_adv),
        .cons_adv_i    (cons_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: begin
                if (in_hs) begin
                    if (in_view.core.msg_type == TCP_MSG_REQ_TYPE && in_flow_ok) begin
                        state_d = ST_LOOKUP;
                    end else if (in_view.core.msg_type == TCP_ADJUST_IDX_TYPE) begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_LOOKUP: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_noc_out_rdy) begin
                    state_d = ST_READY;
                end
            end
            ST_UPDATE: state_d = ST_READY;
            default:   state_d = ST_READY;
        endcase
    end

    always_comb begin
        noc_resp_in_rdy  = (state_q == ST_READY);
        resp_noc_out_val = (state_q == ST_RESP);
        hand_adv         = (state_q == ST_LOOKUP) && q_avail;
        cons_adv         = (state_q == ST_UPDATE) && adj_ok;
        adjust_err       = (state_q == ST_UPDATE) && !adj_ok;
    end

    always_comb begin
        resp_flit                = '0;
        resp_flit.core.dst_x     = req_view.core.src_x;
        resp_flit.core.dst_y     = req_view.core.src_y;
        resp_flit.core.dst_fbits = req_view.core.src_fbits;
        resp_flit.core.src_x     = SRC_X;
        resp_flit.core.src_y     = SRC_Y;
        resp_flit.core.src_fbits = TCP_RX_APP_PTR_IF_FBITS;
        resp_flit.core.msg_type  = TCP_MSG_RESP_TYPE;
        resp_flit.flowid         = req_view.flowid;
        resp_flit.idx            = q_hand;
        // A zero buffer with the current hand index tells the app to retry later.
        resp_flit.buf_info       = q_avail ? tcp_buf'(q_buf) : '0;

        flit_d = in_hs ? noc_resp_in_data : flit_q;
        resp_d = (state_q == ST_LOOKUP) ? resp_flit : resp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_q <= '0;
            resp_q <= '0;
        end else begin
            flit_q <= flit_d;
            resp_q <= resp_d;
        end
    end

    assign resp_noc_out_data = resp_q;

endmodule

// File: tb/tb_tcp_rx_app_buf_responder.sv
// tb/tb_tcp_rx_app_buf_responder.sv - self-checking bench for tcp_rx_app_buf_responder
module tb_tcp_rx_app_buf_responder;
    import tcp_rx_app_buf_responder_pkg::*;

    localparam int OP_FILL = 0;
    localparam int OP_REQ  = 1;
    localparam int OP_ADJ  = 2;
    localparam int OP_DROP = 3;

    typedef struct {
        int          op;
        logic [3:0]  flow;
        logic [31:0] ptr;
        logic [15:0] len;
        logic [3:0]  idx;
        logic [7:0]  bufs;
        logic [15:0] left;
        logic [7:0]  mtype;
        logic        exp_bit;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      noc_resp_in_val;
    logic [NOC_DATA_WIDTH-1:0] noc_resp_in_data;
    logic                      noc_resp_in_rdy;
    logic                      resp_noc_out_val;
    logic [NOC_DATA_WIDTH-1:0] resp_noc_out_data;
    logic                      resp_noc_out_rdy;
    logic                      fill_val;
    logic [MAX_FLOWID_W-1:0]   fill_flowid;
    logic [TCP_BUF_W-1:0]      fill_buf;
    logic                      fill_rdy;
    logic                      adjust_err;

    int checks = 0;
    int errors = 0;
    logic [NOC_DATA_WIDTH-1:0] exp_q[$];
    logic [NOC_DATA_WIDTH-1:0] mon_exp;
    vec_t vecs[$];

    always #5 clk = ~clk;

    tcp_rx_app_buf_responder #(
        .NUM_FLOWS (8),
        .SRC_X     (8'd1),
        .SRC_Y     (8'd2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .noc_resp_in_val   (noc_resp_in_val),
        .noc_resp_in_data  (noc_resp_in_data),
        .noc_resp_in_rdy   (noc_resp_in_rdy),
        .resp_noc_out_val  (resp_noc_out_val),
        .resp_noc_out_data (resp_noc_out_data),
        .resp_noc_out_rdy  (resp_noc_out_rdy),
        .fill_val          (fill_val),
        .fill_flowid       (fill_flowid),
        .fill_buf          (fill_buf),
        .fill_rdy          (fill_rdy),
        .adjust_err        (adjust_err)
    );

    task automatic check(input string name, input logic [NOC_DATA_WIDTH-1:0] act,
                         input logic [NOC_DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NOC_DATA_WIDTH-1:0] mk_req(input logic [7:0] mtype, input logic [3:0] flow);
        tcp_noc_hdr_flit f;
        f                = '0;
        f.core.dst_x     = 8'd1;
        f.core.dst_y     = 8'd2;
        f.core.dst_fbits = TCP_RX_APP_PTR_IF_FBITS;
        f.core.src_x     = 8'd3;
        f.core.src_y     = 8'd4;
        f.core.src_fbits = 4'h7;
        f.core.msg_type  = mtype;
        f.flowid         = flow;
        return f;
    endfunction

    function automatic logic [NOC_DATA_WIDTH-1:0] mk_adj(input logic [3:0] flow, input logic [3:0] idx,
                                                         input logic [7:0] bufs, input logic [15:0] left);
        tcp_adjust_idx_flit a;
        a                         = '0;
        a.core.dst_x              = 8'd1;
        a.core.dst_y              = 8'd2;
        a.core.dst_fbits          = TCP_RX_APP_PTR_IF_FBITS;
        a.core.src_x              = 8'd3;
        a.core.src_y              = 8'd4;
        a.core.src_fbits          = 4'h7;
        a.core.msg_type           = TCP_ADJUST_IDX_TYPE;
        a.flowid                  = flow;
        a.prev_buf.idx            = idx;
        a.bufs_consumed           = bufs;
        a.leftover_bytes_consumed = left;
        return a;
    endfunction

    function automatic logic [NOC_DATA_WIDTH-1:0] mk_resp(input logic [3:0] flow, input logic [3:0] idx,
                                                          input logic [31:0] ptr, input logic [15:0] len);
        tcp_noc_hdr_flit f;
        f                  = '0;
        f.core.dst_x       = 8'd3;
        f.core.dst_y       = 8'd4;
        f.core.dst_fbits   = 4'h7;
        f.core.src_x       = 8'd1;
        f.core.src_y       = 8'd2;
        f.core.src_fbits   = TCP_RX_APP_PTR_IF_FBITS;
        f.core.msg_type    = TCP_MSG_RESP_TYPE;
        f.flowid           = flow;
        f.idx              = idx;
        f.buf_info.ptr     = ptr;
        f.buf_info.len     = len;
        return f;
    endfunction

    function automatic vec_t mkv(input int op, input logic [3:0] flow, input logic [31:0] ptr,
                                 input logic [15:0] len, input logic [3:0] idx, input logic [7:0] bufs,
                                 input logic [15:0] left, input logic [7:0] mtype, input logic exp_bit);
        vec_t v;
        v.op = op; v.flow = flow; v.ptr = ptr; v.len = len; v.idx = idx;
        v.bufs = bufs; v.left = left; v.mtype = mtype; v.exp_bit = exp_bit;
        return v;
    endfunction

    // Scoreboard: each handshaken response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_noc_out_val && resp_noc_out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected no response", resp_noc_out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_flit", resp_noc_out_data, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [NOC_DATA_WIDTH-1:0] f);
        int n = 0;
        while (!noc_resp_in_rdy && n < 100) begin
            tick();
            n++;
        end
        if (!noc_resp_in_rdy) begin
            checks++;
            errors++;
            $display("FAIL in_rdy_timeout: got 0 expected 1");
        end
        noc_resp_in_val  = 1'b1;
        noc_resp_in_data = f;
        tick();
        noc_resp_in_val  = 1'b0;
        noc_resp_in_data = '0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("resp_drained", 256'(exp_q.size()), 256'd0);
        exp_q.delete();
    endtask

    task automatic do_fill(input logic [3:0] flow, input logic [31:0] ptr, input logic [15:0] len,
                           input logic exp_rdy);
        fill_val    = 1'b1;
        fill_flowid = flow;
        fill_buf    = {ptr, len};
        @(negedge clk);
        check("fill_rdy", 256'(fill_rdy), 256'(exp_rdy));
        tick();
        fill_val = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] flow, input logic [3:0] idx, input logic [31:0] ptr,
                          input logic [15:0] len);
        exp_q.push_back(mk_resp(flow, idx, ptr, len));
        send_flit(mk_req(TCP_MSG_REQ_TYPE, flow));
        wait_resp();
    endtask

    task automatic do_adj(input logic [3:0] flow, input logic [3:0] idx, input logic [7:0] bufs,
                          input logic [15:0] left, input logic exp_err);
        send_flit(mk_adj(flow, idx, bufs, left));
        @(negedge clk);
        check("adjust_err", 256'(adjust_err), 256'(exp_err));
        tick();
    endtask

    task automatic do_drop(input logic [7:0] mtype, input logic [3:0] flow);
        logic seen = 1'b0;
        send_flit(mk_req(mtype, flow));
        repeat (6) begin
            @(negedge clk);
            if (resp_noc_out_val || adjust_err) seen = 1'b1;
        end
        tick();
        check("dropped_silent", 256'(seen), 256'd0);
    endtask

    initial begin
        logic [NOC_DATA_WIDTH-1:0] bp_exp;
        int n;

        rst_n            = 1'b0;
        noc_resp_in_val  = 1'b0;
        noc_resp_in_data = '0;
        resp_noc_out_rdy = 1'b1;
        fill_val         = 1'b0;
        fill_flowid      = '0;
        fill_buf         = '0;

        vecs.push_back(mkv(OP_FILL, 4'd2, 32'h1000, 16'd64, 4'd0, 8'd0, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_REQ,  4'd2, 32'h1000, 16'd64, 4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_REQ,  4'd2, 32'h0,    16'd0,  4'd1, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_REQ,  4'd3, 32'h0,    16'd0,  4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_FILL, 4'd3, 32'h3000, 16'd10, 4'd0, 8'd0, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_REQ,  4'd3, 32'h3000, 16'd10, 4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mkv(OP_FILL, 4'd1, 32'h1100 + 32'(k * 16), 16'(100 + k), 4'd0, 8'd0, 16'd0, 8'd0, 1'b1));
        end
        vecs.push_back(mkv(OP_FILL, 4'd1, 32'h1900, 16'd200, 4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_REQ,  4'd1, 32'h1100, 16'd100, 4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd5, 8'd1, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd0, 8'd2, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd0, 8'd1, 16'd3, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd0, 8'd1, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_FILL, 4'd1, 32'h1900, 16'd200, 4'd0, 8'd0, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd1, 8'd1, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_REQ,  4'd1, 32'h1110, 16'd101, 4'd1, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_ADJ,  4'd1, 32'h0, 16'd0, 4'd1, 8'd1, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_REQ,  4'd1, 32'h1120, 16'd102, 4'd2, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_ADJ,  4'd9, 32'h0, 16'd0, 4'd0, 8'd1, 16'd0, 8'd0, 1'b1));
        vecs.push_back(mkv(OP_FILL, 4'd9, 32'h9000, 16'd9, 4'd0, 8'd0, 16'd0, 8'd0, 1'b0));
        vecs.push_back(mkv(OP_DROP, 4'd9, 32'h0, 16'd0, 4'd0, 8'd0, 16'd0, TCP_MSG_REQ_TYPE, 1'b0));
        vecs.push_back(mkv(OP_DROP, 4'd2, 32'h0, 16'd0, 4'd0, 8'd0, 16'd0, 8'h33, 1'b0));
        vecs.push_back(mkv(OP_REQ,  4'd2, 32'h0, 16'd0, 4'd1, 8'd0, 16'd0, 8'd0, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_rdy", 256'(noc_resp_in_rdy), 256'd1);
        check("reset_out_val", 256'(resp_noc_out_val), 256'd0);
        check("reset_out_data", resp_noc_out_data, 256'd0);
        check("reset_adjust_err", 256'(adjust_err), 256'd0);
        check("reset_fill_rdy", 256'(fill_rdy), 256'd1);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_FILL: do_fill(vecs[i].flow, vecs[i].ptr, vecs[i].len, vecs[i].exp_bit);
                OP_REQ:  do_req(vecs[i].flow, vecs[i].idx, vecs[i].ptr, vecs[i].len);
                OP_ADJ:  do_adj(vecs[i].flow, vecs[i].idx, vecs[i].bufs, vecs[i].left, vecs[i].exp_bit);
                default: do_drop(vecs[i].mtype, vecs[i].flow);
            endcase
        end

        // Response backpressure: flit must hold and input must stay blocked.
        do_fill(4'd4, 32'h4444, 16'd44, 1'b1);
        resp_noc_out_rdy = 1'b0;
        bp_exp = mk_resp(4'd4, 4'd0, 32'h4444, 16'd44);
        exp_q.push_back(bp_exp);
        send_flit(mk_req(TCP_MSG_REQ_TYPE, 4'd4));
        tick();
        repeat (10) begin
            @(negedge clk);
            check("bp_out_val", 256'(resp_noc_out_val), 256'd1);
            check("bp_out_data", resp_noc_out_data, bp_exp);
            check("bp_in_rdy", 256'(noc_resp_in_rdy), 256'd0);
        end
        tick();
        resp_noc_out_rdy = 1'b1;
        wait_resp();

        // Twenty fill/handout/retire rounds carry the pointers through 15 -> 0.
        for (int r = 0; r < 20; r++) begin
            do_fill(4'd5, 32'h5000 + 32'(r), 16'(r), 1'b1);
            do_req(4'd5, r[3:0], 32'h5000 + 32'(r), 16'(r));
            do_adj(4'd5, r[3:0], 8'd1, 16'd0, 1'b0);
        end
        do_req(4'd5, 4'd4, 32'h0, 16'd0);

        // Reset while a response is pending.
        do_fill(4'd6, 32'h6666, 16'd66, 1'b1);
        resp_noc_out_rdy = 1'b0;
        exp_q.push_back(mk_resp(4'd6, 4'd0, 32'h6666, 16'd66));
        send_flit(mk_req(TCP_MSG_REQ_TYPE, 4'd6));
        n = 0;
        while (!resp_noc_out_val && n < 20) begin
            tick();
            n++;
        end
        check("pre_reset_out_val", 256'(resp_noc_out_val), 256'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_val", 256'(resp_noc_out_val), 256'd0);
        check("midreset_out_data", resp_noc_out_data, 256'd0);
        exp_q.delete();
        resp_noc_out_rdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_rdy", 256'(noc_resp_in_rdy), 256'd1);
        check("post_reset_out_val", 256'(resp_noc_out_val), 256'd0);
        tick();
        do_fill(4'd6, 32'hAAAA, 16'd7, 1'b1);
        do_req(4'd6, 4'd0, 32'hAAAA, 16'd7);
        do_req(4'd1, 4'd0, 32'h0, 16'd0);
        do_req(4'd5, 4'd0, 32'h0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_rx_app_buf_responder.md
# tcp_rx_app_buf_responder

- Responder end of the TCP RX app-pointer NoC interface (`TCP_RX_APP_PTR_IF_FBITS`). It sits on the TCP engine tile.
- It holds a per-flow ring of `MAX_NUM_BUFS` filled receive buffers (`tcp_buf`).
- On a single-flit `tcp_msg_req` from an application it answers with a `tcp_msg_resp` header flit carrying the next unclaimed buffer and its ring index.
- A `tcp_adjust_idx` flit retires the oldest claimed buffer. A producer-side fill port loads buffers into the ring.

## Interface
- `NUM_FLOWS`, default 8: flows tracked. `MAX_FLOWID_W` must be ≥ clog2(`NUM_FLOWS`).
- `SRC_X`, default 0: this tile's x coordinate, used as the source in response headers.
- `SRC_Y`, default 0: this tile's y coordinate, used as the source in response headers.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `noc_resp_in_val` in 1: incoming header flit valid.
- `noc_resp_in_data` in `NOC_DATA_WIDTH`: incoming `tcp_noc_hdr_flit`.
- `noc_resp_in_rdy` out 1: ready to accept an incoming flit.
- `resp_noc_out_val` out 1: response flit valid.
- `resp_noc_out_data` out `NOC_DATA_WIDTH`: response `tcp_noc_hdr_flit`.
- `resp_noc_out_rdy` in 1: downstream ready for the response flit.
- `fill_val` in 1: producer offers a filled buffer.
- `fill_flowid` in `MAX_FLOWID_W`: flow for the offered buffer.
- `fill_buf` in `TCP_BUF_W`: the offered buffer.
- `fill_rdy` out 1: fill accepted this cycle.
- `adjust_err` out 1: one-cycle pulse when an adjust is rejected.

## Operation
- Per-flow pointers, each `MAX_PAYLOAD_IDX_W+1` bits wide (wrap bit included):
  - `prod`: next slot to fill.
  - `hand`: next slot to hand out.
  - `cons`: oldest unretired slot.
- Slot address is the pointer's low `MAX_PAYLOAD_IDX_W` bits. Invariant: `cons` ≤ `hand` ≤ `prod` (modular).
- Ring full when `prod - cons == MAX_NUM_BUFS`. Nothing to hand out when `hand == prod`.
- FSM states are READY, LOOKUP, RESP and UPDATE. `noc_resp_in_rdy` = (state == READY).
- READY: on accept, latch the flit.
  - `core.msg_type` == `TCP_MSG_REQ_TYPE` → LOOKUP.
  - `core.msg_type` == `TCP_ADJUST_IDX_TYPE` → UPDATE.
  - Any other type: drop, stay in READY.
- LOOKUP: build the response.
  - If a buffer is available: `buf_info` = table[flowid][hand] and `idx` = hand, then increment `hand`.
  - Otherwise: `buf_info` = 0, `idx` = hand, `hand` unchanged. This means "no data"; the app retries.
  - → RESP.
- RESP: hold `resp_noc_out_val` and the data stable until `resp_noc_out_rdy`, then → READY.
- Response header fields:
  - dst = request src x/y/fbits; src = `SRC_X`/`SRC_Y`/`TCP_RX_APP_PTR_IF_FBITS`.
  - `msg_type` = `TCP_MSG_RESP_TYPE`, `msg_len` = 0, `flowid` echoed, padding 0.
- UPDATE: an adjust is accepted only when all four hold:
  - `prev_buf.idx` == `cons`;
  - `bufs_consumed` == 1;
  - `leftover_bytes_consumed` == 0;
  - `cons` != `hand`.
- Accepted adjust: `cons` += 1. Rejected: pointers unchanged, `adjust_err` pulses. Either way → READY.
- Fill path runs independently of the FSM:
  - `fill_rdy` = !full(`fill_flowid`), combinational.
  - On `fill_val && fill_rdy`: table[flowid][prod] ← `fill_buf`, `prod` += 1.
- A fill and a LOOKUP on the same flow in the same cycle: LOOKUP uses the pre-fill `prod`.
- A fill and an UPDATE on the same flow in the same cycle: full is evaluated on the pre-update `cons`.
- A `flowid` ≥ `NUM_FLOWS` on the NoC side is dropped, with `adjust_err` for adjusts. On the fill port it is never accepted (`fill_rdy` = 0).

## Timing
- Reset (`rst_n` low, async):
  - All pointers 0; state READY; `noc_resp_in_rdy` = 1 once out of reset.
  - `resp_noc_out_val` = 0, `resp_noc_out_data` = 0, `adjust_err` = 0.
  - Table contents are don't-care.
- Reset mid-operation aborts any pending response and drops it; no partial flit is emitted.
- Request accepted at cycle T: LOOKUP at T+1, `resp_noc_out_val` high from T+2. Next accept no earlier than the cycle after the response handshake.
- Adjust accepted at T: pointer update and `adjust_err` at T+1, READY at T+2.
- Fill: pointer and table are updated on the accepting edge and are visible to a LOOKUP in the following cycle.
- Pointer arithmetic is modulo 2^(`MAX_PAYLOAD_IDX_W+1`). Wrap from `4'b1111` to `4'b0000` must be handled correctly.

## Structure
- Add to `beehive_tcp_msg`:
  - `TCP_MSG_REQ_TYPE`, `TCP_MSG_RESP_TYPE`, `TCP_ADJUST_IDX_TYPE` msg_type constants;
  - a `tcp_buf_ring_ptrs` struct (`prod`/`hand`/`cons`).
- One sub-module, `tcp_buf_ring_table`: per-flow pointer registers plus the buffer storage, with a fill write port, a handout read/advance port and a retire port. The top level holds the FSM and flit pack/unpack.

## Test plan
- Fill flow 2 with ptr 0x1000/len 64, then request flow 2 → response idx 0, ptr 0x1000, len 64; hand=1.
- Request flow 3 while empty → `buf_info` = 0, idx 0; pointers unchanged.
- Fill flow 1 with 8 buffers → 9th fill sees `fill_rdy` = 0. Request then adjust with idx 0 → `fill_rdy` returns to 1.
- Adjust flow 1 with idx 5 while `cons` = 0, or with `bufs_consumed` = 2 → `adjust_err` pulse; pointers unchanged.
- Hold `resp_noc_out_rdy` low for 10 cycles → data stable, `noc_resp_in_rdy` = 0 throughout. Cycle 20 fill/handout/retire rounds → idx wraps 15→0 correctly.
- Assert `rst_n` low during RESP → `resp_noc_out_val` drops immediately; after release, pointers are 0.
